// File: rtl/key_expansion_ctrl.sv
// rtl/key_expansion_ctrl.sv - iterative round-key schedule sequencer with registered read port
module key_expansion_ctrl #(
    parameter int GEN_LATENCY = 2,
    parameter int NUM_ROUNDS  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic [3:0]   gen_round,
    output logic [127:0] gen_in_key,
    input  logic [127:0] gen_out_key,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data,
    output logic         keys_ready,
    output logic         busy
);
    localparam int CW = (GEN_LATENCY > 0) ? $clog2(GEN_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_DONE   = CW'(GEN_LATENCY);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0]    MAX_ADDR   = 4'(NUM_ROUNDS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    round_cnt;
    logic [3:0]    round_nxt;
    logic [127:0]  rk_mem [NUM_ROUNDS+1];
    logic          accept;
    logic          capture;
    logic          last_capture;

    assign round_nxt = round_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // flush overrides both the key handshake and the generator capture
    always_comb begin
        state_nxt    = state;
        key_ready    = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        last_capture = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                accept    = key_valid && !flush;
                if (accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy         = 1'b1;
                capture      = (wait_cnt == CNT_DONE) && !flush;
                last_capture = capture && (round_cnt == LAST_ROUND);
                if (flush || last_capture) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_round  <= '0;
            gen_in_key <= '0;
            rk_rd_data <= '0;
            keys_ready <= 1'b0;
            wait_cnt   <= '0;
            round_cnt  <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_mem[i] <= '0;
            end
        end else begin
            rk_rd_data <= (rk_rd_addr <= MAX_ADDR) ? rk_mem[rk_rd_addr] : '0;
            if (flush) begin
                keys_ready <= 1'b0;
                wait_cnt   <= '0;
                round_cnt  <= '0;
            end else if (accept) begin
                rk_mem[0]  <= key_in;
                gen_in_key <= key_in;
                gen_round  <= '0;
                round_cnt  <= '0;
                wait_cnt   <= '0;
                keys_ready <= 1'b0;
            end else if (capture) begin
                rk_mem[round_nxt] <= gen_out_key;
                wait_cnt          <= '0;
                if (last_capture) begin
                    keys_ready <= 1'b1;
                    round_cnt  <= '0;
                end else begin
                    // generator inputs stay fixed until the next capture
                    gen_in_key <= gen_out_key;
                    gen_round  <= round_nxt;
                    round_cnt  <= round_nxt;
                end
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb/tb_key_expansion_ctrl.sv - scoreboard bench for key_expansion_ctrl with AES and toy generators
module tb_key_expansion_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic [3:0]   gen_round;
    logic [127:0] gen_in_key;
    logic [127:0] gen_out_key = '0;
    logic [3:0]   rk_rd_addr = '0;
    logic [127:0] rk_rd_data;
    logic         keys_ready;
    logic         busy;

    always #5 clk = ~clk;

    key_expansion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .gen_round(gen_round), .gen_in_key(gen_in_key), .gen_out_key(gen_out_key),
        .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data), .keys_ready(keys_ready), .busy(busy)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0_cyc = 0;
    int done_pending = 0;
    bit toy_mode = 1'b0;
    logic kr_prev = 1'b0;
    logic rd_issue = 1'b0;
    logic rd_live = 1'b0;
    logic [127:0] rd_exp_q[$];
    string rd_name_q[$];
    logic [127:0] gen_s1 = '0;
    int tri_t[11] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55};

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;
            4'd3: return 8'h08;  4'd4: return 8'h10;  4'd5: return 8'h20;
            4'd6: return 8'h40;  4'd7: return 8'h80;  4'd8: return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(r), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // two-stage generator model: valid two edges after its inputs change
    always @(posedge clk) begin
        gen_s1 <= toy_mode ? (gen_in_key + 128'(gen_round) + 128'd1) : aes_next(gen_in_key, gen_round);
        gen_out_key <= gen_s1;
        cyc <= cyc + 1;
        rd_live <= rd_issue;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_live) begin
            if (rd_exp_q.size() == 0) begin
                chk("rd_unexpected", 128'd1, 128'd0);
            end else begin
                chk(rd_name_q.pop_front(), rk_rd_data, rd_exp_q.pop_front());
            end
        end
        if (rst_n && keys_ready && !kr_prev) begin
            if (done_pending == 0) begin
                chk("keys_ready_unexpected", 128'd1, 128'd0);
            end else begin
                done_pending--;
                chk("keys_ready_latency", 128'(cyc - e0_cyc), 128'd30);
            end
        end
        kr_prev = keys_ready;
    end

    task automatic rd(input logic [3:0] a, input logic [127:0] exp, input string nm);
        rk_rd_addr = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(nm);
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic start_key(input logic [127:0] k, input bit expect_done);
        int n = 0;
        key_in = k;
        key_valid = 1'b1;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout", 128'(n < 100), 128'd1);
        @(negedge clk);
        key_valid = 1'b0;
        e0_cyc = cyc;
        if (expect_done) done_pending++;
    endtask

    task automatic track(input logic [127:0] base, input bit toy, input int n);
        for (int i = 0; i < n; i++) begin
            chk("gen_round_step", 128'(gen_round), 128'(i / 3));
            if (toy) chk("gen_in_key_hold", gen_in_key, base + 128'(tri_t[i / 3]));
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!keys_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(keys_ready), 128'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_keys_ready", 128'(keys_ready), 128'd0);
        chk("rst_gen_round", 128'(gen_round), 128'd0);
        chk("rst_gen_in_key", gen_in_key, 128'd0);
        chk("rst_rd_data", rk_rd_data, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'd10, 128'd0, "rst_entry10");

        // FIPS-197 expansion with the AES generator
        toy_mode = 1'b0;
        start_key(FIPS_KEY, 1'b1);
        track(FIPS_KEY, 1'b0, 30);
        chk("aes_done_busy", 128'(busy), 128'd0);
        rd(4'd0, FIPS_KEY, "aes_entry0");
        rd(4'd1, FIPS_RK1, "aes_entry1");
        rd(4'd10, FIPS_RK10, "aes_entry10");
        rd(4'd15, 128'd0, "aes_entry15");

        // toy generator, key 0: triangular schedule
        toy_mode = 1'b1;
        start_key(128'd0, 1'b1);
        track(128'd0, 1'b1, 30);
        rd(4'd0, 128'd0, "toy_entry0");
        rd(4'd5, 128'd15, "toy_entry5");
        rd(4'd10, 128'd55, "toy_entry10");
        rd(4'd15, 128'd0, "toy_entry15");

        // flush in IDLE beats a simultaneous key offer and only clears keys_ready
        flush = 1'b1;
        key_in = 128'hdead;
        key_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        key_valid = 1'b0;
        chk("idle_flush_keys_ready", 128'(keys_ready), 128'd0);
        chk("idle_flush_busy", 128'(busy), 128'd0);
        rd(4'd0, 128'd0, "idle_flush_entry0");

        // flush on edge E0+12, which would otherwise be a capture edge
        start_key(128'h100, 1'b0);
        track(128'h100, 1'b1, 11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 128'(busy), 128'd0);
        chk("flush_key_ready", 128'(key_ready), 128'd1);
        chk("flush_keys_ready", 128'(keys_ready), 128'd0);
        chk("flush_gen_round", 128'(gen_round), 128'd3);
        chk("flush_gen_in_key", gen_in_key, 128'h106);
        repeat (35) @(negedge clk);
        rd(4'd3, 128'h106, "flush_entry3");
        rd(4'd4, 128'd10, "flush_entry4_old");
        start_key(128'h200, 1'b1);
        track(128'h200, 1'b1, 30);
        rd(4'd5, 128'h20f, "post_flush_entry5");
        rd(4'd10, 128'h237, "post_flush_entry10");

        // key B held valid throughout expansion of key A
        chk("hold_pre_key_ready", 128'(key_ready), 128'd1);
        key_in = 128'h1000;
        key_valid = 1'b1;
        @(negedge clk);
        e0_cyc = cyc;
        done_pending++;
        key_in = 128'h5000;
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 1) chk("hold_key_ready_low", 128'(key_ready), 128'd0);
            @(negedge clk);
        end
        chk("hold_done_key_ready", 128'(key_ready), 128'd1);
        rd(4'd10, 128'h1037, "hold_a_entry10");
        chk("hold_b_accepted", 128'(busy), 128'd1);
        chk("hold_b_keys_ready", 128'(keys_ready), 128'd0);
        e0_cyc = cyc;
        done_pending++;
        key_valid = 1'b0;
        rd(4'd1, 128'h1001, "hold_a_entry1");
        rd(4'd0, 128'h5000, "hold_b_entry0");
        wait_done("hold_b_done");
        rd(4'd10, 128'h5037, "hold_b_entry10");

        // asynchronous reset mid-expansion
        start_key(128'h300, 1'b0);
        track(128'h300, 1'b1, 19);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
        chk("mid_rst_gen_round", 128'(gen_round), 128'd0);
        chk("mid_rst_gen_in_key", gen_in_key, 128'd0);
        chk("mid_rst_rd_data", rk_rd_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd10, 128'd0, "mid_rst_entry10");
        rd(4'd0, 128'd0, "mid_rst_entry0");
        start_key(128'h400, 1'b1);
        track(128'h400, 1'b1, 30);
        rd(4'd10, 128'h437, "post_rst_entry10");

        repeat (3) @(negedge clk);
        chk("pending_done_left", 128'(done_pending), 128'd0);
        chk("pending_rd_left", 128'(rd_exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
